// File: rtl/uart_frame_writer.sv
// Framed UART byte stream to BRAM writer: sync hunt, word packing,
// frame completion and inter-byte timeout abort.
module uart_frame_writer #(
  parameter int          BYTES_PER_WORD = 1,
  parameter int          ADDR_W         = 19,
  parameter int          FRAME_WORDS    = 307200,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter int          TIMEOUT_CLKS   = 500000,
  localparam int         DATA_W         = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int LW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [LW-1:0]     LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [TW-1:0]     TMAX      = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOAD
  } state_t;

  state_t              state, state_d;
  logic [LW-1:0]       lane, lane_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [TW-1:0]       timer, timer_d;
  logic [DATA_W-1:0]   pack, pack_d;
  logic [DATA_W-1:0]   packed_word;
  logic [LW+2:0]       off;

  logic                wr_en_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [7:0]          cnt_d;

  // Pack register with the incoming byte merged into the current lane.
  always_comb begin
    off         = {lane, 3'b000};
    packed_word = pack;
    packed_word[off +: 8] = byte_in;
  end

  always_comb begin
    state_d   = state;
    lane_d    = lane;
    addr_d    = addr;
    timer_d   = timer;
    pack_d    = pack;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = frame_cnt;

    unique case (state)
      HUNT: begin
        if (byte_valid && byte_in == SYNC0) begin
          state_d = SYNC;
          timer_d = '0;
        end
      end
      SYNC: begin
        if (byte_valid) begin
          timer_d = '0;
          if (byte_in == SYNC1) begin
            state_d = LOAD;
            lane_d  = '0;
            addr_d  = '0;
          end else if (byte_in != SYNC0) begin
            state_d = HUNT;
          end
        end else if (timer == TMAX) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          timer_d = '0;
          pack_d  = packed_word;
          if (lane == LAST_LANE) begin
            wr_en_d   = 1'b1;
            wr_data_d = packed_word;
            wr_addr_d = addr;
            lane_d    = '0;
            addr_d    = addr + 1'b1;
            if (addr == LAST_ADDR) begin
              done_d  = 1'b1;
              cnt_d   = frame_cnt + 8'd1;
              state_d = HUNT;
            end
          end else begin
            lane_d = lane + 1'b1;
          end
        end else if (timer == TMAX) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      lane       <= '0;
      addr       <= '0;
      timer      <= '0;
      pack       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_d;
      lane       <= lane_d;
      addr       <= addr_d;
      timer      <= timer_d;
      pack       <= pack_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      frame_cnt  <= cnt_d;
    end
  end

endmodule

// File: doc/uart_frame_writer.md
Name: uart_frame_writer

Overview:
Consumes the byte stream from uart_rx (byte_valid/byte_in) and writes one framed image into the dual-port frame BRAM write port. A frame starts with a two-byte sync header, followed by exactly FRAME_WORDS words. Each word is packed from BYTES_PER_WORD bytes, so the same block serves 8-bit and 16-bit pixel formats. Adds header sync, word packing, frame completion, inter-byte timeout and abort, none of which exist in the direct uart-to-BRAM hookup.

Parameters:
BYTES_PER_WORD, 1, bytes packed per BRAM word (legal values 1..4); DATA_W = 8*BYTES_PER_WORD.
ADDR_W, 19, BRAM write address width.
FRAME_WORDS, 307200, words per frame (640x480); must be <= 2**ADDR_W.
SYNC0, 8'hAA, first header byte.
SYNC1, 8'h55, second header byte.
TIMEOUT_CLKS, 500000, idle clk cycles allowed between bytes inside a frame (10 ms at 50 MHz).

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
byte_valid  in  1  one-cycle strobe from uart_rx; strobes may arrive in consecutive cycles
byte_in  in  8  received byte; valid only when byte_valid=1
wr_en  out  1  BRAM write enable, one-cycle pulse per word
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  DATA_W  BRAM write data
busy  out  1  high while in state LOAD
frame_done  out  1  one-cycle pulse, coincident with the final word's wr_en
frame_err  out  1  one-cycle pulse on timeout abort
frame_cnt  out  8  count of completed frames; wraps 255->0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). While rst=1 at a clk edge, every output goes to 0, state goes to HUNT, and the lane index, word address and timer clear. A reset in mid-frame aborts silently: no frame_err and no write.
- All outputs are registered.
- States: HUNT, SYNC, LOAD.
- HUNT: on byte_valid with byte_in==SYNC0, go to SYNC. All other bytes are ignored.
- SYNC, on byte_valid:
  - byte_in==SYNC1: go to LOAD; lane, address and timer clear.
  - byte_in==SYNC0: stay in SYNC.
  - any other byte: go to HUNT.
- LOAD: each byte_valid stores byte_in into lane[lane_idx] of the pack register. Lane 0 is bits [7:0] (little-endian, first byte in the LSBs). lane_idx then increments.
- Word completion: on the byte_valid that fills lane BYTES_PER_WORD-1:
  - In the next cycle: wr_en=1, wr_data=packed word, wr_addr=current word address. Latency is 1 clk from the completing byte_valid.
  - The word address increments and lane_idx returns to 0.
- Final word (address FRAME_WORDS-1): frame_done=1 in the same cycle as that wr_en, frame_cnt increments, state goes to HUNT.
  - A byte arriving in the cycle after the completing byte is evaluated in HUNT.
- Hold behaviour: wr_addr and wr_data hold their last written values while wr_en=0.
- busy is high exactly while state==LOAD.
- Timeout:
  - In SYNC and LOAD, the timer counts clk cycles without byte_valid; any byte_valid clears it.
  - When the timer reaches TIMEOUT_CLKS-1 with no byte_valid: frame_err=1 for one cycle and state goes to HUNT. A partially packed word is discarded and no wr_en is issued.
  - Words already written remain in the BRAM.
  - byte_valid takes priority over the timeout in the same cycle.
- The timer is inactive in HUNT.
- The next frame always starts writing at address 0.
- Back-to-back byte_valid in every cycle must be accepted without loss. Word writes then occur every BYTES_PER_WORD cycles.

Test Plan:
(Bench parameters: BYTES_PER_WORD=2, FRAME_WORDS=4, TIMEOUT_CLKS=100, ADDR_W=4.)
1. Assert rst for 3 clks mid-stream -> all outputs 0, busy=0, frame_cnt=0. The next sync plus data starts at wr_addr=0 and no frame_err is pulsed.
2. Send bytes AA 55 01 02 03 04 05 06 07 08 via 115200-baud UART -> four writes: [0]=0x0201, [1]=0x0403, [2]=0x0605, [3]=0x0807. frame_done coincides with the addr-3 wr_en; frame_cnt=1; busy=0 afterwards.
3. Sync handling:
   - AA AA 55 -> enters LOAD (busy=1).
   - A separate sequence AA 12 55 -> stays in HUNT, no writes.
4. Sync, then 11 22 33, then silence for 100 clks -> one write [0]=0x2211. frame_err pulses once; byte 33 is dropped. A new full frame then writes from addr 0.
5. Drive byte_valid every clk with 00..07 after the sync bytes -> wr_en every 2nd cycle, each 1 clk after the completing byte. frame_done on the 4th write, no bytes lost.
6. Send 256 complete frames -> frame_cnt wraps to 0. Every frame_done is one cycle long and coincides with its last wr_en.
